// File: rtl/conv_pkg.sv
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared constants and window-offset helper for the 4x4 conv feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int KERN       = 4;

    // Bit offset of window element (i,j); i = row (0 oldest), j = column (0 leftmost)
    function automatic int win_off(input int i, input int j, input int dw);
        return (i * KERN + j) * dw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================================
// Module  : conv_line_buffer
// Brief   : DEPTH x WIDTH register array, combinational read and write at the
//           same column index.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents need no reset: a row is only consumed after it has been written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/conv_window_feeder.sv
// ============================================================================
// Module  : conv_window_feeder
// Brief   : Raster pixel stream -> 4x4 sliding windows (stride 1, no padding).
//           Optional macro CONV_FEEDER_WIN_CNT_EN adds the win_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [KERN*KERN*DATA_W-1:0]   out_win,
    output logic [$clog2(IMG_H)-1:0]      out_row,
    output logic [$clog2(IMG_W)-1:0]      out_col,
    output logic                          frame_done
`ifdef CONV_FEEDER_WIN_CNT_EN
    ,
    output logic [15:0]                   win_count
`endif
);

    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W);
    localparam int LBW = (KERN - 1) * DATA_W;

    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_OFF  = RW'(KERN - 1);
    localparam logic [CW-1:0] c_COL_OFF  = CW'(KERN - 1);

    logic [RW-1:0]                 r_row;
    logic [CW-1:0]                 r_col;
    logic [KERN*KERN*DATA_W-1:0]   r_shift;
    logic [KERN*KERN*DATA_W-1:0]   w_shift_next;
    logic [KERN*DATA_W-1:0]        w_col;
    logic [LBW-1:0]                w_lb_rd;
    logic [LBW-1:0]                w_lb_wr;
    logic                          w_accept;
    logic                          w_load;
    logic                          w_win_hit;
    logic                          w_row_last;
    logic                          w_col_last;

    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_load     = w_accept && !clr;
    assign w_row_last = (r_row == c_ROW_LAST);
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_win_hit  = (r_row >= c_ROW_OFF) && (r_col >= c_COL_OFF);

    // Line-buffer word keeps the oldest row in the low slice, so the new
    // column is simply the incoming pixel stacked on top of it.
    assign w_col   = {in_data, w_lb_rd};
    assign w_lb_wr = {in_data, w_lb_rd[LBW-1:DATA_W]};

    conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (LBW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_load),
        .i_addr  (r_col),
        .i_wdata (w_lb_wr),
        .o_rdata (w_lb_rd)
    );

    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < KERN; i++) begin
            for (int j = 0; j < KERN - 1; j++) begin
                w_shift_next[win_off(i, j, DATA_W) +: DATA_W] =
                    r_shift[win_off(i, j + 1, DATA_W) +: DATA_W];
            end
            w_shift_next[win_off(i, KERN - 1, DATA_W) +: DATA_W] =
                w_col[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_col      <= '0;
            r_shift    <= '0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            r_row      <= '0;
            r_col      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_load && w_row_last && w_col_last;
            if (w_load) begin
                r_shift <= w_shift_next;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_load && w_win_hit) begin
                out_valid <= 1'b1;
                out_win   <= w_shift_next;
                out_row   <= r_row - c_ROW_OFF;
                out_col   <= r_col - c_COL_OFF;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_FEEDER_WIN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
        end else if (clr) begin
            win_count <= '0;
        end else if (out_valid && out_ready) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
